// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types plus the load/store stage state and op-class helpers.
package riscv_pkg;

  typedef enum logic [4:0] {
    INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU, INST_XOR,
    INST_SRL, INST_SRA, INST_OR, INST_AND, INST_LUI, INST_AUIPC,
    INST_JAL, INST_JALR, INST_BRANCH,
    INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
    INST_SB, INST_SH, INST_SW
  } inst_type;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  function automatic logic is_mem_op(input inst_type op);
    return op inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
                      INST_SB, INST_SH, INST_SW};
  endfunction

  function automatic logic is_store(input inst_type op);
    return op inside {INST_SB, INST_SH, INST_SW};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign/zero extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  inst_type    i_op,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_result = i_rdata;
    case (i_op)
      INST_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      INST_LBU: o_result = {24'h000000, w_byte};
      INST_LH:  o_result = {{16{w_half[15]}}, w_half};
      INST_LHU: o_result = {16'h0000, w_half};
      default:  o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: single-outstanding req/gnt/rvalid memory port, valid/ready writeback.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into wb_exc traps.
module lsu_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  inst_type        in_op,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exc
);

  lsu_state_t      r_state, w_next;
  inst_type        r_op;
  logic [XLEN-1:0] r_addr, r_rs2, r_wb_data;
  logic [4:0]      r_wb_rd;
  logic            r_rd_we, r_wb_we, r_wb_exc;
  logic            w_accept, w_misalign, w_mem_op;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_load;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (in_op)
      INST_LH, INST_LHU, INST_SH: w_misalign = in_result[0];
      INST_LW, INST_SW:           w_misalign = |in_result[1:0];
      default:                    w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // A trapped access never touches memory, so it takes the pass-through path.
  assign w_mem_op = is_mem_op(in_op) && !w_misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_mem_op ? REQ : DONE;
      REQ:     if (mem_gnt) w_next = WAIT;
      WAIT:    if (mem_rvalid) w_next = DONE;
      DONE:    if (wb_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= INST_ADD;
      r_addr    <= '0;
      r_rs2     <= '0;
      r_rd_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
      r_wb_exc  <= 1'b0;
      r_wb_data <= '0;
    end else if (w_accept) begin
      r_op      <= in_op;
      r_addr    <= in_result;
      r_rs2     <= in_rs2;
      r_rd_we   <= in_rd_we;
      r_wb_rd   <= in_rd;
      r_wb_exc  <= w_misalign;
      r_wb_we   <= in_rd_we && !w_misalign;
      r_wb_data <= in_result;
    end else if (r_state == WAIT && mem_rvalid) begin
      r_wb_we   <= is_store(r_op) ? 1'b0 : r_rd_we;
      r_wb_data <= is_store(r_op) ? '0 : w_load;
    end
  end

  lsu_load_align u_align (
    .i_rdata  (mem_rdata),
    .i_offset (r_addr[1:0]),
    .i_op     (r_op),
    .o_result (w_load)
  );

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    if (r_state == REQ) begin
      case (r_op)
        INST_SB: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_rs2[7:0]}};
        end
        INST_SH: begin
          w_be    = 4'b0011 << {r_addr[1], 1'b0};
          w_wdata = {2{r_rs2[15:0]}};
        end
        INST_SW: begin
          w_be    = 4'b1111;
          w_wdata = r_rs2;
        end
        default: w_be = 4'b1111;
      endcase
    end
  end

  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req && is_store(r_op);
  assign mem_addr  = mem_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_be    = w_be;
  assign mem_wdata = w_wdata;

  assign wb_valid = (r_state == DONE);
  assign wb_rd    = r_wb_rd;
  assign wb_we    = r_wb_we;
  assign wb_data  = r_wb_data;
  assign wb_exc   = r_wb_exc;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed vector table, reset-abort sequence, random ops vs model.
module tb_lsu_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_rd_we;
  inst_type    in_op;
  logic [31:0] in_result, in_rs2;
  logic [4:0]  in_rd;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_ready, wb_we, wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  lsu_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  typedef struct {
    inst_type    op;
    logic [31:0] res, rs2, rdata;
    logic [4:0]  rd;
    logic        rdwe;
    int          gntDly, rvDly, wbDly;
  } stim_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata, wbdata;
    logic        wbwe, exc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic        readyAtStart, sawReq, reqStable, wbStable, inReadyLow, done, idleAfter;
    logic [31:0] addr, wdata, wbdata;
    logic [3:0]  be;
    logic        we, wbwe, exc;
    logic [4:0]  wbrd;
    int          lat;
  } obs_t;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic stim_t mkS(inst_type op, logic [31:0] res, logic [31:0] rs2, logic [31:0] rdata,
                                logic [4:0] rd, logic rdwe, int g, int r, int w);
    stim_t s;
    s.op = op; s.res = res; s.rs2 = rs2; s.rdata = rdata; s.rd = rd; s.rdwe = rdwe;
    s.gntDly = g; s.rvDly = r; s.wbDly = w;
    return s;
  endfunction

  function automatic exp_t mkE(logic req, logic [31:0] addr, logic [3:0] be, logic we,
                               logic [31:0] wdata, logic [31:0] wbdata, logic wbwe, logic exc);
    exp_t e;
    e.req = req; e.addr = addr; e.be = be; e.we = we; e.wdata = wdata;
    e.wbdata = wbdata; e.wbwe = wbwe; e.exc = exc;
    return e;
  endfunction

  // Reference model: bytes touched by an access of a given size at a given address.
  function automatic exp_t modelOp(stim_t s);
    exp_t   e;
    int     size, off;
    bit     isLoad, isStore, isSigned;
    longint v, span;
    e = mkE(0, 0, 0, 0, 0, 0, 0, 0);
    size = 0; isLoad = 0; isStore = 0; isSigned = 0;
    case (s.op)
      INST_LB:  begin size = 1; isLoad = 1; isSigned = 1; end
      INST_LBU: begin size = 1; isLoad = 1; end
      INST_LH:  begin size = 2; isLoad = 1; isSigned = 1; end
      INST_LHU: begin size = 2; isLoad = 1; end
      INST_LW:  begin size = 4; isLoad = 1; end
      INST_SB:  begin size = 1; isStore = 1; end
      INST_SH:  begin size = 2; isStore = 1; end
      INST_SW:  begin size = 4; isStore = 1; end
      default:  size = 0;
    endcase
    if (size == 0) begin
      e.wbdata = s.res;
      e.wbwe = s.rdwe;
      return e;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (s.res % size != 0) begin
      e.exc = 1; e.wbdata = s.res; e.wbwe = 0;
      return e;
    end
`endif
    off = int'(s.res % 4);
    off = off - off % size;
    e.req = 1;
    e.addr = s.res - (s.res % 4);
    e.we = isStore;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = isLoad || (i >= off && i < off + size);
      if (isStore) e.wdata[8*i +: 8] = s.rs2[8*(i % size) +: 8];
    end
    if (isLoad) begin
      span = longint'(1) << (8 * size);
      v = longint'(s.rdata >> (8 * off)) % span;
      if (isSigned && v >= span / 2) v = v - span;
      e.wbdata = v[31:0];
      e.wbwe = s.rdwe;
    end
    return e;
  endfunction

  // Drives one op and plays the memory and writeback sides with the requested delays.
  task automatic applyStimulus(input stim_t s, output obs_t o);
    int   reqCnt, waitCnt, holdCnt;
    logic granted, seenWb;
    o = '{default: 0};
    o.reqStable = 1; o.wbStable = 1; o.inReadyLow = 1;
    reqCnt = 0; waitCnt = 0; holdCnt = 0; granted = 0; seenWb = 0;
    @(negedge clk);
    o.readyAtStart = in_ready;
    in_valid = 1; in_op = s.op; in_result = s.res; in_rs2 = s.rs2; in_rd = s.rd; in_rd_we = s.rdwe;
    wb_ready = 0; mem_gnt = 0; mem_rvalid = 0;
    for (int cyc = 1; cyc <= 60 && !o.done; cyc++) begin
      @(negedge clk);
      in_valid = 0; in_op = INST_SUB; in_result = $urandom; in_rs2 = $urandom;
      in_rd = 5'($urandom); in_rd_we = 1'($urandom);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom; wb_ready = 0;
      if (wb_valid) begin
        if (!seenWb) begin
          seenWb = 1; o.lat = cyc;
          o.wbdata = wb_data; o.wbwe = wb_we; o.wbrd = wb_rd; o.exc = wb_exc;
        end else if ({wb_data, wb_we, wb_rd, wb_exc} !== {o.wbdata, o.wbwe, o.wbrd, o.exc}) begin
          o.wbStable = 0;
        end
        if (in_ready) o.inReadyLow = 0;
        if (holdCnt == s.wbDly) begin wb_ready = 1; o.done = 1; end
        holdCnt++;
      end else if (mem_req) begin
        if (!o.sawReq) begin
          o.sawReq = 1; o.addr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {o.addr, o.be, o.we, o.wdata}) begin
          o.reqStable = 0;
        end
        if (in_ready) o.inReadyLow = 0;
        if (reqCnt == s.gntDly) begin mem_gnt = 1; granted = 1; end
        else mem_rvalid = 1;
        reqCnt++;
      end else if (granted) begin
        if (in_ready) o.inReadyLow = 0;
        if (waitCnt == s.rvDly) begin mem_rvalid = 1; mem_rdata = s.rdata; end
        waitCnt++;
      end
    end
    @(negedge clk);
    wb_ready = 0; mem_gnt = 0; mem_rvalid = 0;
    o.idleAfter = !wb_valid && in_ready;
  endtask

  task automatic checkTxn(input string tag, input stim_t s, input exp_t e, input obs_t o);
    checkOutput({tag, ".done"}, o.done, 1);
    checkOutput({tag, ".readyAtStart"}, o.readyAtStart, 1);
    checkOutput({tag, ".req"}, o.sawReq, e.req);
    if (e.req) begin
      checkOutput({tag, ".addr"}, o.addr, e.addr);
      checkOutput({tag, ".be"}, o.be, e.be);
      checkOutput({tag, ".we"}, o.we, e.we);
      if (e.we) checkOutput({tag, ".wdata"}, o.wdata, e.wdata);
      checkOutput({tag, ".reqStable"}, o.reqStable, 1);
      checkOutput({tag, ".latency"}, o.lat, 3 + s.gntDly + s.rvDly);
    end else begin
      checkOutput({tag, ".latency"}, o.lat, 1);
    end
    checkOutput({tag, ".wbData"}, o.wbdata, e.wbdata);
    checkOutput({tag, ".wbWe"}, o.wbwe, e.wbwe);
    checkOutput({tag, ".wbRd"}, o.wbrd, s.rd);
    checkOutput({tag, ".wbExc"}, o.exc, e.exc);
    checkOutput({tag, ".wbStable"}, o.wbStable, 1);
    checkOutput({tag, ".inReadyLow"}, o.inReadyLow, 1);
    checkOutput({tag, ".idleAfter"}, o.idleAfter, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t     vecs[$];
    obs_t     o;
    stim_t    s;
    exp_t     e;
    inst_type ops[11];
    ops = '{INST_ADD, INST_XOR, INST_SUB, INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
            INST_SB, INST_SH, INST_SW};

    vecs.push_back('{mkS(INST_ADD, 32'h0000_1234, 0, 0, 5, 1, 0, 0, 0),
                     mkE(0, 0, 0, 0, 0, 32'h0000_1234, 1, 0)});
    vecs.push_back('{mkS(INST_LB, 32'h0100_0003, 0, 32'h80FF_FF7F, 7, 1, 0, 0, 0),
                     mkE(1, 32'h0100_0000, 4'hF, 0, 0, 32'hFFFF_FF80, 1, 0)});
    vecs.push_back('{mkS(INST_LBU, 32'h0100_0003, 0, 32'h80FF_FF7F, 8, 1, 0, 0, 0),
                     mkE(1, 32'h0100_0000, 4'hF, 0, 0, 32'h0000_0080, 1, 0)});
    vecs.push_back('{mkS(INST_SH, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1111_1111, 9, 1, 3, 0, 0),
                     mkE(1, 32'h0000_2000, 4'b1100, 1, 32'hBEEF_BEEF, 0, 0, 0)});
    vecs.push_back('{mkS(INST_LH, 32'h0000_0000, 0, 32'h1234_8001, 10, 1, 0, 0, 5),
                     mkE(1, 32'h0000_0000, 4'hF, 0, 0, 32'hFFFF_8001, 1, 0)});
    vecs.push_back('{mkS(INST_LH, 32'h0000_0002, 0, 32'h1234_8001, 11, 1, 0, 1, 5),
                     mkE(1, 32'h0000_0000, 4'hF, 0, 0, 32'h0000_1234, 1, 0)});
    vecs.push_back('{mkS(INST_LHU, 32'h0000_0012, 0, 32'h8001_1234, 12, 1, 1, 1, 1),
                     mkE(1, 32'h0000_0010, 4'hF, 0, 0, 32'h0000_8001, 1, 0)});
    vecs.push_back('{mkS(INST_SB, 32'h0000_3001, 32'h1234_56A5, 0, 13, 1, 0, 2, 0),
                     mkE(1, 32'h0000_3000, 4'b0010, 1, 32'hA5A5_A5A5, 0, 0, 0)});
    vecs.push_back('{mkS(INST_SW, 32'h0000_4004, 32'hCAFE_F00D, 0, 14, 1, 2, 0, 0),
                     mkE(1, 32'h0000_4004, 4'hF, 1, 32'hCAFE_F00D, 0, 0, 0)});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{mkS(INST_LW, 32'h0000_1001, 0, 32'h1122_3344, 15, 1, 0, 0, 0),
                     mkE(0, 0, 0, 0, 0, 32'h0000_1001, 0, 1)});
`else
    vecs.push_back('{mkS(INST_LW, 32'h0000_1001, 0, 32'h1122_3344, 15, 1, 0, 0, 0),
                     mkE(1, 32'h0000_1000, 4'hF, 0, 0, 32'h1122_3344, 1, 0)});
`endif
    vecs.push_back('{mkS(INST_ADD, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 2),
                     mkE(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0)});
    vecs.push_back('{mkS(INST_LB, 32'h0000_5000, 0, 32'h0000_007F, 0, 1, 0, 0, 0),
                     mkE(1, 32'h0000_5000, 4'hF, 0, 0, 32'h0000_007F, 1, 0)});

    reset = 1; in_valid = 0; in_op = INST_ADD; in_result = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; wb_ready = 0;
    #23;
    checkOutput("resetOutputs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_we, wb_data, wb_exc}, 0);
    checkOutput("resetInReady", in_ready, 1);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s, o);
      checkTxn($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, o);
    end

    // Abort a load in WAIT with reset; the late rvalid must land in IDLE and be dropped.
    @(negedge clk);
    in_valid = 1; in_op = INST_LW; in_result = 32'h0000_0800; in_rd = 3; in_rd_we = 1;
    @(negedge clk);
    in_valid = 0;
    checkOutput("abortReq", mem_req, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    checkOutput("abortInWait", {mem_req, in_ready, wb_valid}, 3'b000);
    reset = 1;
    #1;
    checkOutput("abortResetOutputs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_we, wb_data, wb_exc}, 0);
    checkOutput("abortResetInReady", in_ready, 1);
    @(negedge clk);
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("abortQuiet%0d", c), {mem_req, wb_valid, wb_we, wb_data, in_ready}, 1);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      s = mkS(ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      e = modelOp(s);
      applyStimulus(s, o);
      checkTxn($sformatf("rnd%0d", i), s, e, o);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
